id_ex_stage: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use hazard detection, sitting directly upstream of the EX-stage ALU.
- Latches decoded instruction fields at the ID/EX boundary.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU control code and both ALU operands.
- Raises a stall request to IF/ID on load-use hazards and inserts a bubble into EX.

---
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded fields, forwards from EX/MEM and MEM/WB
// into the ALU operands, and holds back IF/ID with a bubble on load-use hazards.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [2:0]        id_aluctrl_i,
    input  logic              id_alusrc_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rdata1_i,
    input  logic [DATA_W-1:0] id_rdata2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_alures_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_wdata_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [2:0]        ex_aluctrl_o,
    output logic [DATA_W-1:0] ex_opa_o,
    output logic [DATA_W-1:0] ex_opb_o,
    output logic [DATA_W-1:0] ex_storedata_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o
);

    logic              ex_valid;
    logic [2:0]        ex_aluctrl;
    logic              ex_alusrc;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_memtoreg;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;

    logic              load_en;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign hazard_rs1 = id_uses_rs1_i && (id_rs1_i == ex_rd);
    assign hazard_rs2 = id_uses_rs2_i && (id_rs2_i == ex_rd);
    assign stall_o    = !flush_i && id_valid_i && ex_valid && ex_memread &&
                        (ex_rd != '0) && (hazard_rs1 || hazard_rs2);

    assign load_en = !flush_i && !stall_o && id_valid_i;

    // Any rejected capture loads an all-zero bubble, which also keeps x0 indices
    // in the register so a bubble can never match a forwarding source.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid    <= 1'b0;
            ex_aluctrl  <= '0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
        end else begin
            ex_valid    <= load_en;
            ex_aluctrl  <= load_en ? id_aluctrl_i  : '0;
            ex_alusrc   <= load_en ? id_alusrc_i   : 1'b0;
            ex_regwrite <= load_en ? id_regwrite_i : 1'b0;
            ex_memread  <= load_en ? id_memread_i  : 1'b0;
            ex_memwrite <= load_en ? id_memwrite_i : 1'b0;
            ex_memtoreg <= load_en ? id_memtoreg_i : 1'b0;
            ex_rs1      <= load_en ? id_rs1_i      : '0;
            ex_rs2      <= load_en ? id_rs2_i      : '0;
            ex_rd       <= load_en ? id_rd_i       : '0;
            ex_rdata1   <= load_en ? id_rdata1_i   : '0;
            ex_rdata2   <= load_en ? id_rdata2_i   : '0;
            ex_imm      <= load_en ? id_imm_i      : '0;
        end
    end

    // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_a = ex_rdata1;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs1)) begin
            fwd_a = exmem_alures_i;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs1)) begin
            fwd_a = memwb_wdata_i;
        end
    end

    always_comb begin
        fwd_b = ex_rdata2;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs2)) begin
            fwd_b = exmem_alures_i;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs2)) begin
            fwd_b = memwb_wdata_i;
        end
    end

    assign ex_opa_o       = fwd_a;
    assign ex_opb_o       = ex_alusrc ? ex_imm : fwd_b;
    assign ex_storedata_o = fwd_b;

    assign ex_valid_o    = ex_valid;
    assign ex_aluctrl_o  = ex_aluctrl;
    assign ex_rd_o       = ex_rd;
    assign ex_regwrite_o = ex_regwrite && ex_valid;
    assign ex_memread_o  = ex_memread  && ex_valid;
    assign ex_memwrite_o = ex_memwrite && ex_valid;
    assign ex_memtoreg_o = ex_memtoreg && ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each driven ID slot predicts the EX outputs
// for the following cycle, which are popped and compared once that cycle arrives.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              id_valid_i;
    logic [2:0]        id_aluctrl_i;
    logic              id_alusrc_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              id_memwrite_i;
    logic              id_memtoreg_i;
    logic              id_uses_rs1_i;
    logic              id_uses_rs2_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic [DATA_W-1:0] id_rdata1_i;
    logic [DATA_W-1:0] id_rdata2_i;
    logic [DATA_W-1:0] id_imm_i;
    logic              exmem_regwrite_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic [DATA_W-1:0] exmem_alures_i;
    logic              memwb_regwrite_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [DATA_W-1:0] memwb_wdata_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic [2:0]        ex_aluctrl_o;
    logic [DATA_W-1:0] ex_opa_o;
    logic [DATA_W-1:0] ex_opb_o;
    logic [DATA_W-1:0] ex_storedata_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_regwrite_o;
    logic              ex_memread_o;
    logic              ex_memwrite_o;
    logic              ex_memtoreg_o;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_aluctrl_i(id_aluctrl_i), .id_alusrc_i(id_alusrc_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .exmem_alures_i(exmem_alures_i), .memwb_regwrite_i(memwb_regwrite_i),
        .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_aluctrl_o(ex_aluctrl_o),
        .ex_opa_o(ex_opa_o), .ex_opb_o(ex_opb_o), .ex_storedata_o(ex_storedata_o),
        .ex_rd_o(ex_rd_o), .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic              valid;
        logic [2:0]        aluctrl;
        logic              alusrc, regwrite, memread, memwrite, memtoreg, uses1, uses2;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [DATA_W-1:0] rdata1, rdata2, imm;
    } txn_t;

    typedef struct {
        logic              exwe;
        logic [REG_AW-1:0] exrd;
        logic [DATA_W-1:0] exres;
        logic              wbwe;
        logic [REG_AW-1:0] wbrd;
        logic [DATA_W-1:0] wbdata;
    } fwd_t;

    typedef struct {
        logic              valid;
        logic [2:0]        aluctrl;
        logic [DATA_W-1:0] opa, opb, store;
        logic [REG_AW-1:0] rd;
        logic              regwrite, memread, memwrite, memtoreg;
    } exp_t;

    exp_t sb_q[$];
    txn_t mdl;
    fwd_t cur_fwd;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    function automatic txn_t bubble();
        txn_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic txn_t instr(logic [2:0] op, logic alusrc, logic rw, logic mr,
                                   logic mw, logic m2r, logic u1, logic u2,
                                   logic [REG_AW-1:0] rs1, logic [REG_AW-1:0] rs2,
                                   logic [REG_AW-1:0] rd, logic [DATA_W-1:0] d1,
                                   logic [DATA_W-1:0] d2, logic [DATA_W-1:0] imm);
        txn_t t;
        t.valid = 1'b1; t.aluctrl = op; t.alusrc = alusrc; t.regwrite = rw;
        t.memread = mr; t.memwrite = mw; t.memtoreg = m2r; t.uses1 = u1; t.uses2 = u2;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rdata1 = d1; t.rdata2 = d2; t.imm = imm;
        return t;
    endfunction

    function automatic fwd_t fw(logic exwe, logic [REG_AW-1:0] exrd, logic [DATA_W-1:0] exres,
                                logic wbwe, logic [REG_AW-1:0] wbrd, logic [DATA_W-1:0] wbdata);
        fwd_t f;
        f.exwe = exwe; f.exrd = exrd; f.exres = exres;
        f.wbwe = wbwe; f.wbrd = wbrd; f.wbdata = wbdata;
        return f;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.valid = ($urandom_range(0, 3) != 0);
        t.aluctrl = 3'($urandom_range(0, 7));
        t.alusrc = 1'($urandom_range(0, 1));
        t.regwrite = 1'($urandom_range(0, 1));
        t.memread = 1'($urandom_range(0, 1));
        t.memwrite = 1'($urandom_range(0, 1));
        t.memtoreg = 1'($urandom_range(0, 1));
        t.uses1 = 1'($urandom_range(0, 1));
        t.uses2 = 1'($urandom_range(0, 1));
        t.rs1 = REG_AW'($urandom_range(0, 3));
        t.rs2 = REG_AW'($urandom_range(0, 3));
        t.rd = REG_AW'($urandom_range(0, 3));
        t.rdata1 = $urandom;
        t.rdata2 = $urandom;
        t.imm = $urandom;
        return t;
    endfunction

    function automatic fwd_t rand_fwd();
        return fw(1'($urandom_range(0, 1)), REG_AW'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), REG_AW'($urandom_range(0, 3)), $urandom);
    endfunction

    function automatic logic [DATA_W-1:0] fwd_value(logic [REG_AW-1:0] rs,
                                                    logic [DATA_W-1:0] latched, fwd_t f);
        if (f.exwe && f.exrd != 0 && f.exrd == rs) return f.exres;
        if (f.wbwe && f.wbrd != 0 && f.wbrd == rs) return f.wbdata;
        return latched;
    endfunction

    function automatic exp_t predict(txn_t t, fwd_t f);
        exp_t e;
        e.valid    = t.valid;
        e.aluctrl  = t.aluctrl;
        e.opa      = fwd_value(t.rs1, t.rdata1, f);
        e.store    = fwd_value(t.rs2, t.rdata2, f);
        e.opb      = t.alusrc ? t.imm : e.store;
        e.rd       = t.rd;
        e.regwrite = t.regwrite & t.valid;
        e.memread  = t.memread & t.valid;
        e.memwrite = t.memwrite & t.valid;
        e.memtoreg = t.memtoreg & t.valid;
        return e;
    endfunction

    function automatic logic model_stall(txn_t id, logic flush, txn_t ex);
        return !flush && id.valid && ex.valid && ex.memread && ex.rd != 0 &&
               ((id.uses1 && id.rs1 == ex.rd) || (id.uses2 && id.rs2 == ex.rd));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareEx(input exp_t e);
        checkOutput("ex_valid", ex_valid_o, e.valid);
        checkOutput("ex_aluctrl", ex_aluctrl_o, e.aluctrl);
        checkOutput("ex_opa", ex_opa_o, e.opa);
        checkOutput("ex_opb", ex_opb_o, e.opb);
        checkOutput("ex_storedata", ex_storedata_o, e.store);
        checkOutput("ex_rd", ex_rd_o, e.rd);
        checkOutput("ex_regwrite", ex_regwrite_o, e.regwrite);
        checkOutput("ex_memread", ex_memread_o, e.memread);
        checkOutput("ex_memwrite", ex_memwrite_o, e.memwrite);
        checkOutput("ex_memtoreg", ex_memtoreg_o, e.memtoreg);
    endtask

    task automatic driveId(input txn_t t);
        id_valid_i = t.valid; id_aluctrl_i = t.aluctrl; id_alusrc_i = t.alusrc;
        id_regwrite_i = t.regwrite; id_memread_i = t.memread; id_memwrite_i = t.memwrite;
        id_memtoreg_i = t.memtoreg; id_uses_rs1_i = t.uses1; id_uses_rs2_i = t.uses2;
        id_rs1_i = t.rs1; id_rs2_i = t.rs2; id_rd_i = t.rd;
        id_rdata1_i = t.rdata1; id_rdata2_i = t.rdata2; id_imm_i = t.imm;
    endtask

    task automatic driveFwd(input fwd_t f);
        exmem_regwrite_i = f.exwe; exmem_rd_i = f.exrd; exmem_alures_i = f.exres;
        memwb_regwrite_i = f.wbwe; memwb_rd_i = f.wbrd; memwb_wdata_i = f.wbdata;
    endtask

    // Called at a falling edge: check the instruction now in EX, then predict the capture.
    task automatic applyStimulus(input txn_t id, input fwd_t next_fwd, input logic flush);
        exp_t e;
        logic exp_stall;
        txn_t cap;
        driveId(id);
        flush_i = flush;
        driveFwd(cur_fwd);
        #1;
        exp_stall = model_stall(id, flush, mdl);
        checkOutput("stall", stall_o, exp_stall);
        checkOutput("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compareEx(e);
        end
        cap = (flush || exp_stall || !id.valid) ? bubble() : id;
        mdl = cap;
        cur_fwd = next_fwd;
        sb_q.push_back(predict(cap, next_fwd));
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic restartModel();
        mdl = bubble();
        cur_fwd = fw(0, 0, 0, 0, 0, 0);
        sb_q.delete();
        sb_q.push_back(predict(bubble(), cur_fwd));
    endtask

    task automatic resetMid();
        rst_i = 1'b0;
        #1;
        compareEx(predict(bubble(), cur_fwd));
        checkOutput("stall_in_reset", stall_o, 0);
        id_valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        restartModel();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t none, add1, sub1, and1, xor1, inv, ld6, addi7, nr, ld0, r0, st;
        fwd_t nofwd;
        nofwd = fw(0, 0, 0, 0, 0, 0);
        none  = bubble();

        rst_i = 1'b0;
        driveId(rand_txn());
        driveFwd(rand_fwd());
        flush_i = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        compareEx(predict(bubble(), nofwd));
        checkOutput("stall_in_reset", stall_o, 0);
        id_valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        restartModel();

        add1  = instr(3'b000, 0, 1, 0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        sub1  = instr(3'b001, 0, 1, 0, 0, 0, 1, 1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd9, 32'd0);
        and1  = instr(3'b010, 0, 1, 0, 0, 0, 1, 1, 5'd9, 5'd5, 5'd8, 32'h99, 32'h55, 32'd0);
        xor1  = instr(3'b011, 1, 1, 0, 0, 0, 1, 0, 5'd9, 5'd5, 5'd10, 32'h99, 32'h55, 32'hFFFF_FFFC);
        ld6   = instr(3'b111, 1, 1, 1, 0, 1, 1, 0, 5'd2, 5'd0, 5'd6, 32'h1000, 32'd0, 32'd4);
        addi7 = instr(3'b111, 1, 1, 0, 0, 0, 1, 0, 5'd6, 5'd0, 5'd7, 32'hDEAD, 32'd0, 32'd1);
        nr    = instr(3'b000, 1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd0, 5'd9, 32'd0, 32'd0, 32'h5000);
        ld0   = instr(3'b111, 1, 1, 1, 0, 1, 1, 0, 5'd2, 5'd0, 5'd0, 32'h1000, 32'd0, 32'd4);
        r0    = instr(3'b000, 0, 1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0);
        st    = instr(3'b000, 1, 0, 0, 1, 0, 1, 1, 5'd2, 5'd3, 5'd0, 32'd1, 32'd2, 32'd8);
        inv   = xor1;
        inv.valid = 1'b0;

        applyStimulus(add1, nofwd, 0);
        applyStimulus(sub1, fw(1, 5'd3, 32'd12, 0, 0, 0), 0);
        applyStimulus(sub1, fw(1, 5'd0, 32'd12, 0, 0, 0), 0);
        applyStimulus(and1, fw(1, 5'd5, 32'h11, 1, 5'd5, 32'h22), 0);
        applyStimulus(xor1, fw(1, 5'd5, 32'h11, 1, 5'd5, 32'h22), 0);
        applyStimulus(inv, nofwd, 0);

        applyStimulus(add1, nofwd, 0);
        resetMid();

        applyStimulus(ld6, nofwd, 0);
        applyStimulus(addi7, fw(1, 5'd6, 32'h1004, 0, 0, 0), 0);
        applyStimulus(addi7, fw(0, 0, 0, 1, 5'd6, 32'hCAFE), 0);
        applyStimulus(none, nofwd, 0);

        applyStimulus(ld6, nofwd, 0);
        applyStimulus(nr, nofwd, 0);
        applyStimulus(ld0, nofwd, 0);
        applyStimulus(r0, nofwd, 0);

        applyStimulus(ld6, nofwd, 0);
        applyStimulus(addi7, nofwd, 1);
        applyStimulus(st, nofwd, 1);
        applyStimulus(none, nofwd, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(rand_txn(), rand_fwd(), ($urandom_range(0, 7) == 0));
        end
        applyStimulus(none, nofwd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
